// File: rtl/mask_index_iter_if.sv
// mask_index_iter_if: handshake bundle for mask_index_iter
//   in_valid_i/in_ready_o/in_mask_i : mask input handshake
//   flush_i                         : synchronous abort
//   out_valid_o/out_ready_i         : index output handshake
//   out_idx_o/out_last_o/out_seq_o  : index, final-bit flag, ordinal
//   zero_mask_o/busy_o              : all-zero pulse, iteration in progress
interface mask_index_iter_if #(
  parameter int WIDTH = 32
);
  localparam int IDX_W = WIDTH > 1 ? $clog2(WIDTH) : 1;
  localparam int SEQ_W = $clog2(WIDTH + 1);
  logic             in_valid_i;
  logic             in_ready_o;
  logic [WIDTH-1:0] in_mask_i;
  logic             flush_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [IDX_W-1:0] out_idx_o;
  logic             out_last_o;
  logic [SEQ_W-1:0] out_seq_o;
  logic             zero_mask_o;
  logic             busy_o;
  modport slave (
    input  in_valid_i, in_mask_i, flush_i, out_ready_i,
    output in_ready_o, out_valid_o, out_idx_o, out_last_o, out_seq_o, zero_mask_o, busy_o
  );
  modport master (
    output in_valid_i, in_mask_i, flush_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_idx_o, out_last_o, out_seq_o, zero_mask_o, busy_o
  );
endinterface

// File: rtl/mask_index_iter.sv
// mask_index_iter: emits the positions of set bits of an accepted mask, one per handshake
//   clk_i  : clock, rising edge
//   rst_ni : asynchronous active-low reset
//   bus    : mask_index_iter_if slave (input mask handshake, flush, index output handshake, status)
//   MODE   : 0 = lowest set bit first, 1 = highest set bit first
module mask_index_iter #(
  parameter int WIDTH = 32,
  parameter bit MODE  = 1'b0
) (
  input logic             clk_i,
  input logic             rst_ni,
  mask_index_iter_if.slave bus
);
  localparam int IDX_W = WIDTH > 1 ? $clog2(WIDTH) : 1;
  localparam int SEQ_W = $clog2(WIDTH + 1);
  typedef enum logic {IDLE, ITER} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic [SEQ_W-1:0] seq_q, seq_d;
  logic             zero_q, zero_d;
  logic [IDX_W-1:0] idx;
  logic             single, valid, accept, fire;
  // Priority pick; the last matching iteration wins, so scan toward the preferred end.
  always_comb begin
    idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (MODE) begin
        if (pend_q[i]) idx = IDX_W'(i);
      end else if (pend_q[WIDTH-1-i]) begin
        idx = IDX_W'(WIDTH-1-i);
      end
    end
  end
  // Exactly one bit set: nonzero and clearing the lowest set bit leaves nothing.
  assign single = (|pend_q) && ~|(pend_q & (pend_q - WIDTH'(1)));
  assign valid  = (state_q == ITER) && !bus.flush_i;
  assign accept = bus.in_valid_i && bus.in_ready_o;
  assign fire   = valid && bus.out_ready_i;
  assign bus.in_ready_o  = (state_q == IDLE) && !bus.flush_i;
  assign bus.out_valid_o = valid;
  assign bus.out_idx_o   = valid ? idx : '0;
  assign bus.out_last_o  = valid && single;
  assign bus.out_seq_o   = valid ? seq_q : '0;
  assign bus.zero_mask_o = zero_q;
  assign bus.busy_o      = state_q == ITER;
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    seq_d   = seq_q;
    zero_d  = 1'b0;
    if (bus.flush_i) begin
      state_d = IDLE;
      pend_d  = '0;
      seq_d   = '0;
    end else if (accept) begin
      if (|bus.in_mask_i) begin
        state_d = ITER;
        pend_d  = bus.in_mask_i;
        seq_d   = '0;
      end else begin
        zero_d = 1'b1;
      end
    end else if (fire) begin
      pend_d[idx] = 1'b0;
      seq_d       = single ? '0 : seq_q + SEQ_W'(1);
      state_d     = single ? IDLE : ITER;
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      pend_q  <= '0;
      seq_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      seq_q   <= seq_d;
      zero_q  <= zero_d;
    end
  end
endmodule

// File: tb/tb_mask_index_iter.sv
// tb_mask_index_iter: scoreboard bench for mask_index_iter (WIDTH 8 both modes, WIDTH 1)
module tb_mask_index_iter;
  typedef struct packed {logic [2:0] idx; logic last; logic [3:0] seq;} exp_t;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       v = 1'b0, flush = 1'b0, rdy = 1'b0;
  logic [7:0] mask = '0;
  logic       v1 = 1'b0, m1 = 1'b0, rdy1 = 1'b0;
  int         cmp = 0, bad = 0;
  exp_t       q0[$], q1[$];
  exp_t       e;
  always #5 clk = ~clk;
  mask_index_iter_if #(.WIDTH(8)) if0 ();
  mask_index_iter_if #(.WIDTH(8)) if1 ();
  mask_index_iter_if #(.WIDTH(1)) ifw ();
  assign if0.in_valid_i = v;  assign if0.in_mask_i = mask; assign if0.flush_i = flush; assign if0.out_ready_i = rdy;
  assign if1.in_valid_i = v;  assign if1.in_mask_i = mask; assign if1.flush_i = flush; assign if1.out_ready_i = rdy;
  assign ifw.in_valid_i = v1; assign ifw.in_mask_i = m1;   assign ifw.flush_i = 1'b0;  assign ifw.out_ready_i = rdy1;
  mask_index_iter #(.WIDTH(8), .MODE(1'b0)) dut0 (.clk_i(clk), .rst_ni(rst_n), .bus(if0));
  mask_index_iter #(.WIDTH(8), .MODE(1'b1)) dut1 (.clk_i(clk), .rst_ni(rst_n), .bus(if1));
  mask_index_iter #(.WIDTH(1), .MODE(1'b0)) dutw (.clk_i(clk), .rst_ni(rst_n), .bus(ifw));
  wire [7:0] t0 = {if0.out_idx_o, if0.out_last_o, if0.out_seq_o};
  wire [7:0] t1 = {if1.out_idx_o, if1.out_last_o, if1.out_seq_o};
  function automatic void expect_mask(input logic [7:0] m);
    int n = $countones(m);
    int k = 0;
    for (int i = 0; i < 8; i++)
      if (m[i]) begin q0.push_back('{3'(i), k == n - 1, 4'(k)}); k++; end
    k = 0;
    for (int i = 7; i >= 0; i--)
      if (m[i]) begin q1.push_back('{3'(i), k == n - 1, 4'(k)}); k++; end
  endfunction
  task automatic test_reset;
    #2;
    cmp++; if (if0.in_ready_o !== 1'b1)  begin bad++; $display("FAIL rst_in_ready got %b exp 1", if0.in_ready_o); end
    cmp++; if (if0.out_valid_o !== 1'b0) begin bad++; $display("FAIL rst_out_valid got %b exp 0", if0.out_valid_o); end
    cmp++; if (t0 !== 8'h00)             begin bad++; $display("FAIL rst_tuple got %h exp 00", t0); end
    cmp++; if (if0.zero_mask_o !== 1'b0) begin bad++; $display("FAIL rst_zero got %b exp 0", if0.zero_mask_o); end
    cmp++; if (if1.busy_o !== 1'b0)      begin bad++; $display("FAIL rst_busy got %b exp 0", if1.busy_o); end
    flush = 1'b1; #1;
    cmp++; if (if0.in_ready_o !== 1'b0)  begin bad++; $display("FAIL rst_flush_ready got %b exp 0", if0.in_ready_o); end
    flush = 1'b0;
    @(negedge clk); rst_n = 1'b1;
  endtask
  task automatic test_order;
    expect_mask(8'hA6);
    @(negedge clk); v = 1'b1; mask = 8'hA6; rdy = 1'b1; #1;
    cmp++; if ({if0.in_ready_o, if1.in_ready_o} !== 2'b11) begin bad++; $display("FAIL order_accept got %b exp 11", {if0.in_ready_o, if1.in_ready_o}); end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); v = 1'b0; #1;
      e = q0.size() ? q0.pop_front() : '1;
      cmp++; if (!if0.out_valid_o || t0 !== e) begin bad++; $display("FAIL order_lsb[%0d] got v%b %h exp %h", k, if0.out_valid_o, t0, e); end
      e = q1.size() ? q1.pop_front() : '1;
      cmp++; if (!if1.out_valid_o || t1 !== e) begin bad++; $display("FAIL order_msb[%0d] got v%b %h exp %h", k, if1.out_valid_o, t1, e); end
    end
    @(negedge clk); #1;
    cmp++; if ({if0.in_ready_o, if1.in_ready_o, if0.busy_o, if1.out_valid_o} !== 4'b1100) begin bad++;
      $display("FAIL order_idle got %b exp 1100", {if0.in_ready_o, if1.in_ready_o, if0.busy_o, if1.out_valid_o}); end
  endtask
  task automatic test_zero;
    @(negedge clk); v = 1'b1; mask = 8'h00; #1;
    cmp++; if (if0.zero_mask_o !== 1'b0) begin bad++; $display("FAIL zero_early got %b exp 0", if0.zero_mask_o); end
    @(negedge clk); v = 1'b0; #1;
    cmp++; if ({if0.zero_mask_o, if1.zero_mask_o, if0.out_valid_o, if0.in_ready_o} !== 4'b1101) begin bad++;
      $display("FAIL zero_pulse got %b exp 1101", {if0.zero_mask_o, if1.zero_mask_o, if0.out_valid_o, if0.in_ready_o}); end
    @(negedge clk); #1;
    cmp++; if ({if0.zero_mask_o, if0.out_valid_o, if0.in_ready_o} !== 3'b001) begin bad++;
      $display("FAIL zero_after got %b exp 001", {if0.zero_mask_o, if0.out_valid_o, if0.in_ready_o}); end
  endtask
  task automatic test_stall;
    logic [3:0] pat = 4'b1001;
    int n0 = 0, n1 = 0;
    expect_mask(8'hFF);
    @(negedge clk); v = 1'b1; mask = 8'hFF; rdy = 1'b0;
    for (int c = 0; c < 40 && (q0.size() || q1.size()); c++) begin
      @(negedge clk); v = 1'b0; rdy = pat[c % 4]; #1;
      if (if0.out_valid_o) begin
        e = q0.size() ? q0[0] : '1;
        cmp++; if (t0 !== e) begin bad++; $display("FAIL stall_lsb c%0d got %h exp %h", c, t0, e); end
        if (rdy && q0.size()) begin void'(q0.pop_front()); n0++; end
      end
      if (if1.out_valid_o) begin
        e = q1.size() ? q1[0] : '1;
        cmp++; if (t1 !== e) begin bad++; $display("FAIL stall_msb c%0d got %h exp %h", c, t1, e); end
        if (rdy && q1.size()) begin void'(q1.pop_front()); n1++; end
      end
    end
    cmp++; if (n0 != 8 || n1 != 8) begin bad++; $display("FAIL stall_count got %0d/%0d exp 8/8", n0, n1); end
    @(negedge clk); rdy = 1'b1; #1;
    cmp++; if ({if0.busy_o, if1.busy_o} !== 2'b00) begin bad++; $display("FAIL stall_done got %b exp 00", {if0.busy_o, if1.busy_o}); end
  endtask
  task automatic test_flush;
    expect_mask(8'hF0);
    @(negedge clk); v = 1'b1; mask = 8'hF0; rdy = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); v = 1'b0; #1;
      e = q0.pop_front();
      cmp++; if (t0 !== e) begin bad++; $display("FAIL flush_pre_lsb[%0d] got %h exp %h", k, t0, e); end
      e = q1.pop_front();
      cmp++; if (t1 !== e) begin bad++; $display("FAIL flush_pre_msb[%0d] got %h exp %h", k, t1, e); end
    end
    q0.delete(); q1.delete();
    @(negedge clk); flush = 1'b1; v = 1'b1; mask = 8'h0F; #1;
    cmp++; if ({if0.out_valid_o, if1.out_valid_o, if0.in_ready_o, t0} !== 11'h0) begin bad++;
      $display("FAIL flush_cycle got %h exp 0", {if0.out_valid_o, if1.out_valid_o, if0.in_ready_o, t0}); end
    @(negedge clk); flush = 1'b0; v = 1'b0; #1;
    cmp++; if ({if0.busy_o, if1.busy_o, if0.out_valid_o, if0.in_ready_o} !== 4'b0001) begin bad++;
      $display("FAIL flush_idle got %b exp 0001", {if0.busy_o, if1.busy_o, if0.out_valid_o, if0.in_ready_o}); end
    expect_mask(8'h01);
    @(negedge clk); v = 1'b1; mask = 8'h01;
    @(negedge clk); v = 1'b0; #1;
    e = q0.pop_front();
    cmp++; if (!if0.out_valid_o || t0 !== e) begin bad++; $display("FAIL flush_new_lsb got %h exp %h", t0, e); end
    e = q1.pop_front();
    cmp++; if (!if1.out_valid_o || t1 !== e) begin bad++; $display("FAIL flush_new_msb got %h exp %h", t1, e); end
    @(negedge clk); #1;
    cmp++; if ({if0.out_valid_o, if1.out_valid_o} !== 2'b00) begin bad++; $display("FAIL flush_end got %b exp 00", {if0.out_valid_o, if1.out_valid_o}); end
  endtask
  task automatic test_async_reset;
    @(negedge clk); v = 1'b1; mask = 8'hF0; rdy = 1'b1;
    @(negedge clk); v = 1'b0; #1;
    cmp++; if (t0 !== 8'h80) begin bad++; $display("FAIL arst_first got %h exp 80", t0); end
    #2 rst_n = 1'b0; #1;
    cmp++; if ({if0.out_valid_o, if1.out_valid_o, if0.busy_o, t0, t1, if0.in_ready_o} !== 20'h1) begin bad++;
      $display("FAIL arst_outputs got %h exp 1", {if0.out_valid_o, if1.out_valid_o, if0.busy_o, t0, t1, if0.in_ready_o}); end
    @(negedge clk); rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      cmp++; if ({if0.out_valid_o, if1.out_valid_o} !== 2'b00) begin bad++; $display("FAIL arst_after[%0d] got %b exp 00", c, {if0.out_valid_o, if1.out_valid_o}); end
    end
  endtask
  task automatic test_width1;
    @(negedge clk); v1 = 1'b1; m1 = 1'b1; rdy1 = 1'b1;
    @(negedge clk); v1 = 1'b0; #1;
    cmp++; if ({ifw.out_valid_o, ifw.out_idx_o, ifw.out_last_o, ifw.out_seq_o} !== 4'b1010) begin bad++;
      $display("FAIL w1_xfer got %b exp 1010", {ifw.out_valid_o, ifw.out_idx_o, ifw.out_last_o, ifw.out_seq_o}); end
    @(negedge clk); v1 = 1'b1; m1 = 1'b0; #1;
    cmp++; if ({ifw.out_valid_o, ifw.in_ready_o} !== 2'b01) begin bad++; $display("FAIL w1_idle got %b exp 01", {ifw.out_valid_o, ifw.in_ready_o}); end
    @(negedge clk); v1 = 1'b0; #1;
    cmp++; if ({ifw.zero_mask_o, ifw.out_valid_o} !== 2'b10) begin bad++; $display("FAIL w1_zero got %b exp 10", {ifw.zero_mask_o, ifw.out_valid_o}); end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end
  initial begin
    test_reset;
    test_order;
    test_zero;
    test_stall;
    test_flush;
    test_async_reset;
    test_width1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
